md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 SHALL have port `clk`, input, 1 bit: rising-edge clock, shared with the pipeline registers.
REQ-003 SHALL have port `reset`, input, 1 bit: asynchronous, active-high.
REQ-004 SHALL have port `start`, input, 1 bit: EX-stage request, sampled on the rising edge.
REQ-005 SHALL have port `op`, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port `a`, input, 32 bits: forwarded rs operand (multiplicand or dividend).
REQ-007 SHALL have port `b`, input, 32 bits: forwarded rt operand (multiplier or divisor).
REQ-008 SHALL have port `flush`, input, 1 bit: aborts the in-flight operation.
REQ-009 SHALL have port `hi_we`, input, 1 bit: MTHI write strobe.
REQ-010 SHALL have port `lo_we`, input, 1 bit: MTLO write strobe.
REQ-011 SHALL have port `wdata`, input, 32 bits: MTHI/MTLO data.
REQ-012 SHALL have port `busy`, output, 1 bit: operation in progress; drives the hazard-unit stall.
REQ-013 SHALL have port `done`, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port `div_by_zero`, output, 1 bit: one-cycle pulse, coincident with `done`.
REQ-015 SHALL have port `hi`, output, 32 bits: HI register, read by MFHI.
REQ-016 SHALL have port `lo`, output, 32 bits: LO register, read by MFLO.

Function
REQ-017 SHALL implement the FSM states IDLE, RUN and FIN; `busy` is 1 only in RUN, and `done` is 1 only in FIN.
REQ-018 SHALL, in IDLE or FIN, latch the operands and op and enter RUN with iteration counter 0 on an edge where `start`=1 (edge E0).
REQ-019 SHALL perform one iteration per edge in RUN; at edge E32 it SHALL write HI/LO and enter FIN.
REQ-020 SHALL, as a result, hold `busy` high for 32 cycles and hold `done` high for the single cycle after E32, then return to IDLE.
REQ-021 SHALL, in FIN with `start`=1, go directly to RUN; `done` is still high for that one cycle.
REQ-022 SHALL compute multiply by shift-add on operand magnitudes, with a two's-complement fix-up of the 64-bit product for MULT; result is HI = product[63:32], LO = product[31:0].
REQ-023 SHALL compute divide by restoring division on magnitudes, with LO = quotient and HI = remainder.
REQ-024 SHALL, for signed DIV, truncate the quotient toward zero and give the remainder the sign of the dividend.
REQ-025 SHALL return LO=0x80000000, HI=0 for DIV 0x80000000 / 0xFFFFFFFF, with no exception.
REQ-026 SHALL, for DIV or DIVU with `b`=0 at E0, skip RUN: go to FIN at E0, pulse `done` and `div_by_zero` in the next cycle, and leave HI/LO unchanged.
REQ-027 SHALL ignore `start` in RUN; the operand latches and counter are unaffected.
REQ-028 SHALL, on `flush`=1 in RUN, return to IDLE at that edge, leave HI/LO unchanged and produce no `done`.
REQ-029 SHALL give `flush` priority over `start` at the same edge; in IDLE or FIN, `flush` has no effect.
REQ-030 SHALL apply `hi_we`/`lo_we` writes of `wdata` at the edge only in IDLE or FIN; they are ignored in RUN.
REQ-031 SHALL, when `start`=1 and `hi_we`/`lo_we`=1 at the same edge, accept `start` and drop the write.
REQ-032 SHALL keep all arithmetic internal to 64-bit/33-bit datapaths; no output is ever X after reset.

Reset
REQ-033 SHALL, while `reset`=1, asynchronously force: state IDLE, counter 0, `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0.
REQ-034 SHALL apply reset asserted mid-operation immediately, discarding partial results; the first `start` after reset release behaves as from power-up.

Verification
REQ-035 Bench SHALL cover: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> `busy` for 32 cycles, `done` on cycle 33 after the start edge, HI=0xFFFFFFFE, LO=0x00000001.
REQ-036 Bench SHALL cover: MULT a=0xFFFFFFFD (-3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then MULT 0x80000000 * 0x80000000 -> HI=0x40000000, LO=0.
REQ-037 Bench SHALL cover: DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-038 Bench SHALL cover: MTHI 0x1234 then DIV a=5, b=0 -> `done`=`div_by_zero`=1 in the cycle after start, HI=0x1234 unchanged, `busy` never 1.
REQ-039 Bench SHALL cover: `flush` at iteration 5 of a MULTU -> `busy`=0 next cycle, no `done`, HI/LO keep prior values; a `start` pulse during RUN is ignored (still exactly one `done`).
REQ-040 Bench SHALL cover: `reset` asserted between edges at iteration 10 -> `busy`, `hi`, `lo` go to 0 before the next edge; `hi_we` with `start` in IDLE -> write dropped.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: iterative HI/LO multiply-divide unit, 32 shift-add or restoring-divide
// iterations per operation, with MTHI/MTLO writes, flush and divide-by-zero bypass.
module md_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic        na_q, na_d, nb_q, nb_d, dbz_q, dbz_d;
    logic [31:0] m_q, m_d, acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        a_neg, b_neg, b_zero, neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] madd, shl;
    logic [33:0] diff;
    logic [31:0] mul_hi, mul_lo, div_hi, div_lo, it_hi, it_lo, quo, rem, res_hi, res_lo;
    logic [63:0] prod, mres;

    always_comb begin
        a_neg  = ~op[0] & a[31];
        b_neg  = ~op[0] & b[31];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        b_zero = op[1] & (b == 32'd0);
        // acc_hi holds the partial product / remainder, acc_lo the multiplier / quotient
        madd   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, m_q} : 33'd0);
        mul_hi = madd[32:1];
        mul_lo = {madd[0], acc_lo_q[31:1]};
        shl    = {acc_hi_q, acc_lo_q[31]};
        diff   = {1'b0, shl} - {2'b00, m_q};
        div_hi = diff[33] ? shl[31:0] : diff[31:0];
        div_lo = {acc_lo_q[30:0], ~diff[33]};
        it_hi  = op_q[1] ? div_hi : mul_hi;
        it_lo  = op_q[1] ? div_lo : mul_lo;
        neg    = na_q ^ nb_q;
        prod   = {mul_hi, mul_lo};
        mres   = neg ? -prod : prod;
        quo    = neg ? -div_lo : div_lo;
        rem    = na_q ? -div_hi : div_hi;
        res_hi = op_q[1] ? rem : mres[63:32];
        res_lo = op_q[1] ? quo : mres[31:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        na_d     = na_q;
        nb_d     = nb_q;
        m_d      = m_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = 1'b0;
        if (state_q == RUN) begin
            if (flush) begin
                state_d = IDLE;
            end else begin
                acc_hi_d = it_hi;
                acc_lo_d = it_lo;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIN;
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                end
            end
        end else if (start) begin
            op_d     = op;
            na_d     = a_neg;
            nb_d     = b_neg;
            m_d      = b_mag;
            acc_hi_d = 32'd0;
            acc_lo_d = a_mag;
            cnt_d    = 5'd0;
            state_d  = b_zero ? FIN : RUN;
            dbz_d    = b_zero;
        end else begin
            state_d = IDLE;
            hi_d    = hi_we ? wdata : hi_q;
            lo_d    = lo_we ? wdata : lo_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            op_q     <= 2'd0;
            na_q     <= 1'b0;
            nb_q     <= 1'b0;
            m_q      <= 32'd0;
            acc_hi_q <= 32'd0;
            acc_lo_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            na_q     <= na_d;
            nb_q     <= nb_d;
            m_q      <= m_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == FIN);
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed vectors for md_unit; expected results are queued at issue
// time and a monitor compares them whenever the unit signals done.
module tb_md_unit;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = 32'd0, b = 32'd0, wdata = 32'd0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int          total = 0, bad = 0, pushes = 0, dones = 0;
    logic [64:0] sb[$];
    logic [64:0] e_mon;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

    md_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (div_by_zero === 1'b1 && done !== 1'b1)
            check("dbz_without_done", {63'd0, div_by_zero}, 64'd0);
        if (done === 1'b1) begin
            dones++;
            if (sb.size() == 0) begin
                check("spurious_done", {63'd0, done}, 64'd0);
            end else begin
                e_mon = sb.pop_front();
                check("div_by_zero", {63'd0, div_by_zero}, {63'd0, e_mon[64]});
                check("hi", {32'd0, hi}, {32'd0, e_mon[63:32]});
                check("lo", {32'd0, lo}, {32'd0, e_mon[31:0]});
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit push, input logic [31:0] eh, input logic [31:0] el,
                         input logic ed);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1 start = 1'b0;
        if (push) begin
            sb.push_back({ed, eh, el});
            pushes++;
            m_hi = eh;
            m_lo = el;
        end
    endtask

    task automatic wait_done(input int exp_busy, input int pulse_at);
        int nb = 0, nc = 0;
        do begin
            @(negedge clk);
            nc++;
            start = (nc == pulse_at);
            if (start) begin
                op = 2'b11; a = 32'd100; b = 32'd0;
            end
            if (busy) nb++;
        end while (done !== 1'b1 && nc < 100);
        start = 1'b0;
        check("busy_cycles", 64'(nb), 64'(exp_busy));
        check("done_cycle", 64'(nc), 64'(exp_busy + 1));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        reset = 1'b0;

        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        wait_done(32, 0);
        issue(2'b00, 32'hFFFFFFFD, 32'd7, 1, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        wait_done(32, 0);
        issue(2'b00, 32'h80000000, 32'h80000000, 1, 32'h40000000, 32'h00000000, 1'b0);
        wait_done(32, 0);
        issue(2'b10, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        wait_done(32, 0);
        issue(2'b11, 32'd7, 32'd2, 1, 32'd1, 32'd3, 1'b0);
        wait_done(32, 0);
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1, 32'd0, 32'h80000000, 1'b0);
        wait_done(32, 0);

        @(negedge clk);
        hi_we = 1'b1; wdata = 32'h1234;
        @(posedge clk);
        #1 hi_we = 1'b0;
        check("mthi", {32'd0, hi}, 64'h1234);
        issue(2'b10, 32'd5, 32'd0, 1, 32'h1234, 32'h80000000, 1'b1);
        wait_done(0, 0);

        issue(2'b01, 32'd3, 32'd5, 0, 32'd0, 32'd0, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_done", {63'd0, done}, 64'd0);
        repeat (5) @(negedge clk);
        check("flush_hi", {32'd0, hi}, {32'd0, m_hi});
        check("flush_lo", {32'd0, lo}, {32'd0, m_lo});

        issue(2'b01, 32'd3, 32'd5, 1, 32'd0, 32'd15, 1'b0);
        wait_done(32, 4);
        repeat (3) @(negedge clk);

        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'd0, 32'd0, 1'b0);
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_hi", {32'd0, hi}, 64'd0);
        check("midrst_lo", {32'd0, lo}, 64'd0);
        @(negedge clk) reset = 1'b0;

        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3; hi_we = 1'b1; wdata = 32'hDEAD;
        @(posedge clk);
        #1 start = 1'b0; hi_we = 1'b0;
        sb.push_back({1'b0, 32'd0, 32'd6});
        pushes++;
        check("hi_we_dropped", {32'd0, hi}, 64'd0);
        wait_done(32, 0);

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        check("done_count", 64'(dones), 64'(pushes));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
